// File: rtl/edge_event_arbiter.sv
// Edge-event collector: synchronises level inputs, detects enabled edges,
// holds one pending event per channel and serves them round-robin.
module edge_event_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] rise_en,
  input  logic [NUM_CH-1:0] fall_en,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rising,
  output logic [NUM_CH-1:0] overflow,
  input  logic              ovf_clr
);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_s;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] gnt_oh;
  logic [NUM_CH-1:0] ovf_set;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic              load;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain and previous-level register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_s;
    end
  end

  // Enabled edge detection on the synchronised level
  always_comb begin
    rise     = sync_s & ~prev_q & rise_en;
    fall     = ~sync_s & prev_q & fall_en;
    edge_det = rise | fall;
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && pend_v[(int'(last_grant) + i) % NUM_CH]) begin
        found = 1'b1;
        grant = CH_W'((int'(last_grant) + i) % NUM_CH);
      end
    end
    load   = (!evt_valid || evt_ready) && found;
    gnt_oh = '0;
    if (load) gnt_oh[grant] = 1'b1;
    ovf_set = edge_det & pend_v & ~gnt_oh;
  end

  // Pending slots: a slot granted this cycle may reload with a new edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v <= '0;
      pend_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (edge_det[i] && (!pend_v[i] || gnt_oh[i])) begin
          pend_v[i] <= 1'b1;
          pend_r[i] <= rise[i];
        end else if (gnt_oh[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flags; a new drop wins over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= '0;
    else overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
  end

  // Output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      evt_rising <= 1'b0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      evt_valid  <= 1'b1;
      evt_ch     <= grant;
      evt_rising <= pend_r[grant];
      last_grant <= grant;
    end else if (evt_ready) begin
      evt_valid  <= 1'b0;
    end
  end

endmodule
